// File: rtl/ttc_tdm_encoder.sv
// TTC line encoder: A (L1A) and B (command frame) channels time-multiplexed onto one biphase-mark stream.
// Optional feature macro TTC_FRAME_CNT_EN adds frames_sent / l1a_sent counters.
module ttc_tdm_encoder #(
  parameter int unsigned CMD_FIFO_DEPTH = 8,
  parameter int unsigned MIN_GAP        = 1
) (
  input  logic                              clk160,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              a_channel,
  input  logic [41:0]                       cmd_frame,
  input  logic                              cmd_long,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  output logic [$clog2(CMD_FIFO_DEPTH):0]   fifo_level,
  output logic                              busy,
  output logic                              bc_strobe,
  output logic                              a_overrun,
  output logic                              ttc_bit_out
`ifdef TTC_FRAME_CNT_EN
  ,
  output logic [31:0]                       frames_sent,
  output logic [31:0]                       l1a_sent
`endif
);

  localparam int unsigned FW   = 42;
  localparam int unsigned SW   = 16;
  localparam int unsigned PADW = FW - SW;
  localparam int unsigned AW   = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned CW   = 6;
  localparam int unsigned GW   = 4;

  typedef struct packed {
    logic          is_long;
    logic [FW-1:0] frame;
  } cmd_t;

  typedef enum logic [1:0] {B_IDLE, B_DATA, B_GAP} b_state_t;

  logic [1:0]    phase;
  logic          a_bit;
  logic          a_pending;

  cmd_t          mem [CMD_FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic          push;
  logic          pop;

  b_state_t      b_state;
  b_state_t      b_state_next;
  logic [CW-1:0] bits_left;
  logic [CW-1:0] bits_next;
  logic [GW-1:0] gap_left;
  logic [GW-1:0] gap_next;
  logic [FW-1:0] sr;
  logic [FW-1:0] sr_next;
  logic [FW-1:0] aligned;
  logic          b_bit;
  logic          b_bit_next;
  logic          busy_next;

  assign push = cmd_valid & cmd_ready;
  assign head = mem[rd_ptr];

  // Cell phase and bunch-crossing strobe (strobe is high while phase==0)
  always_ff @(posedge clk160 or negedge rst) begin
    if (!rst) begin
      phase     <= 2'd0;
      bc_strobe <= 1'b0;
    end else begin
      phase     <= phase + 2'd1;
      bc_strobe <= (phase == 2'd3);
    end
  end

  // Command FIFO bookkeeping
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  always_ff @(posedge clk160 or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cmd_ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      cmd_ready  <= (level_next != LW'(CMD_FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk160) begin
    if (push) mem[wr_ptr] <= {cmd_long, cmd_frame};
  end

  // B channel: all decisions happen on the edge that opens the B cell
  always_comb begin
    b_state_next = b_state;
    bits_next    = bits_left;
    gap_next     = gap_left;
    sr_next      = sr;
    b_bit_next   = b_bit;
    busy_next    = busy;
    pop          = 1'b0;
    aligned      = head.frame;
    if (!head.is_long) aligned = {head.frame[SW-1:0], PADW'(0)};
    if (phase == 2'd2) begin
      b_bit_next = 1'b1;
      case (b_state)
        B_DATA: begin
          b_bit_next = sr[FW-1];
          sr_next    = {sr[FW-2:0], 1'b0};
          bits_next  = bits_left - CW'(1);
          if (bits_left == CW'(1)) begin
            if (MIN_GAP == 0) begin
              b_state_next = B_IDLE;
              busy_next    = 1'b0;
            end else begin
              b_state_next = B_GAP;
              gap_next     = GW'(MIN_GAP);
            end
          end
        end
        B_GAP: begin
          gap_next = gap_left - GW'(1);
          if (gap_left == GW'(1)) begin
            b_state_next = B_IDLE;
            busy_next    = 1'b0;
          end
        end
        default: begin
          if (enable && (fifo_level != '0)) begin
            pop          = 1'b1;
            b_bit_next   = aligned[FW-1];
            sr_next      = {aligned[FW-2:0], 1'b0};
            bits_next    = head.is_long ? CW'(FW - 1) : CW'(SW - 1);
            busy_next    = 1'b1;
            b_state_next = B_DATA;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk160 or negedge rst) begin
    if (!rst) begin
      b_state   <= B_IDLE;
      bits_left <= '0;
      gap_left  <= '0;
      sr        <= '0;
      b_bit     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      b_state   <= b_state_next;
      bits_left <= bits_next;
      gap_left  <= gap_next;
      sr        <= sr_next;
      b_bit     <= b_bit_next;
      busy      <= busy_next;
    end
  end

  // A channel request latching and BPM line coding
  always_ff @(posedge clk160 or negedge rst) begin
    if (!rst) begin
      a_bit       <= 1'b0;
      a_pending   <= 1'b0;
      a_overrun   <= 1'b0;
      ttc_bit_out <= 1'b0;
    end else begin
      if (phase == 2'd0) begin
        a_bit     <= a_pending | a_channel;
        a_pending <= 1'b0;
      end else begin
        a_pending <= a_pending | a_channel;
      end
      a_overrun <= (phase != 2'd0) & a_pending & a_channel;
      case (phase)
        2'd1:    ttc_bit_out <= ttc_bit_out ^ a_bit;
        2'd3:    ttc_bit_out <= ttc_bit_out ^ b_bit;
        default: ttc_bit_out <= ~ttc_bit_out;
      endcase
    end
  end

`ifdef TTC_FRAME_CNT_EN
  always_ff @(posedge clk160 or negedge rst) begin
    if (!rst) begin
      frames_sent <= '0;
      l1a_sent    <= '0;
    end else begin
      if (pop) frames_sent <= frames_sent + 32'd1;
      if ((phase == 2'd0) && (a_pending | a_channel)) l1a_sent <= l1a_sent + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ttc_tdm_encoder.sv
// Bench for ttc_tdm_encoder: decodes the BPM stream and compares against a frame/bit-queue reference model.
module tb_ttc_tdm_encoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 1;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk160;
  logic          rst;
  logic          enable;
  logic          a_channel;
  logic [41:0]   cmd_frame;
  logic          cmd_long;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          bc_strobe;
  logic          a_overrun;
  logic          ttc_bit_out;
`ifdef TTC_FRAME_CNT_EN
  logic [31:0]   frames_sent;
  logic [31:0]   l1a_sent;
`endif

  ttc_tdm_encoder #(.CMD_FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
    .clk160      (clk160),
    .rst         (rst),
    .enable      (enable),
    .a_channel   (a_channel),
    .cmd_frame   (cmd_frame),
    .cmd_long    (cmd_long),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .bc_strobe   (bc_strobe),
    .a_overrun   (a_overrun),
    .ttc_bit_out (ttc_bit_out)
`ifdef TTC_FRAME_CNT_EN
    ,
    .frames_sent (frames_sent),
    .l1a_sent    (l1a_sent)
`endif
  );

  initial begin
    clk160 = 1'b0;
    forever #5 clk160 = ~clk160;
  end

  int          checks;
  int          errors;
  int          edge_idx;
  int          a_win;
  int          m_frames;
  int          m_l1a;
  int          max_level;
  int          a_ones;
  int          ovr_seen;
  logic        exp_a;
  logic        exp_b;
  logic        exp_ovr;
  logic        exp_bc;
  logic        m_ready;
  logic        prev_out;
  logic [42:0] mq[$];
  logic        bq[$];
  logic [63:0] b_hist;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    bq.delete();
    a_win    = 0;
    m_ready  = 1'b1;
    edge_idx = 0;
    prev_out = 1'b0;
    exp_a    = 1'b0;
    exp_b    = 1'b1;
    exp_ovr  = 1'b0;
    exp_bc   = 1'b0;
    m_frames = 0;
    m_l1a    = 0;
  endtask

  // Reference: one L1A per A cell for any requests in its window; frames expand to bit lists plus idle gap
  task automatic model_edge(input int p);
    logic [42:0] c;
    int          len;
    logic        pushing;
    exp_bc  = (p == 3);
    pushing = cmd_valid && m_ready;
    if (p == 0) begin
      exp_a   = (a_win > 0) || a_channel;
      exp_ovr = 1'b0;
      a_win   = 0;
      if (exp_a) m_l1a++;
    end else begin
      exp_ovr = a_channel && (a_win > 0);
      if (a_channel) a_win++;
    end
    if (p == 2) begin
      if (bq.size() > 0) begin
        exp_b = bq.pop_front();
      end else if (enable && mq.size() > 0) begin
        c   = mq.pop_front();
        len = c[42] ? 42 : 16;
        for (int i = len - 1; i >= 0; i--) bq.push_back(c[i]);
        for (int g = 0; g < int'(GAP); g++) bq.push_back(1'b1);
        exp_b = bq.pop_front();
        m_frames++;
      end else begin
        exp_b = 1'b1;
      end
    end
    if (pushing) mq.push_back({cmd_long, cmd_frame});
    m_ready = (mq.size() != int'(DEPTH));
  endtask

  task automatic tick();
    int   p;
    logic t;
    @(posedge clk160);
    p = edge_idx % 4;
    model_edge(p);
    #1;
    edge_idx++;
    t = ttc_bit_out ^ prev_out;
    case (p)
      0, 2: check("bpm_toggle", 64'(t), 64'(1));
      1: begin
        check("a_decode", 64'(t), 64'(exp_a));
        if (t) a_ones++;
      end
      default: begin
        check("b_decode", 64'(t), 64'(exp_b));
        b_hist = {b_hist[62:0], t};
      end
    endcase
    prev_out = ttc_bit_out;
    if (a_overrun) ovr_seen++;
    check("cmd_ready", 64'(cmd_ready), 64'(m_ready));
    check("fifo_level", 64'(fifo_level), 64'(mq.size()));
    check("busy", 64'(busy), 64'(bq.size() > 0));
    check("bc_strobe", 64'(bc_strobe), 64'(exp_bc));
    check("a_overrun", 64'(a_overrun), 64'(exp_ovr));
`ifdef TTC_FRAME_CNT_EN
    check("frames_sent", 64'(frames_sent), 64'(m_frames));
    check("l1a_sent", 64'(l1a_sent), 64'(m_l1a));
`endif
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  endtask

  task automatic wait_phase(input int p);
    while (edge_idx % 4 != p) tick();
  endtask

  task automatic push_cmd(input logic lng, input logic [41:0] f);
    logic acc;
    int   n;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_long  = lng;
    cmd_frame = f;
    do begin
      acc = m_ready;
      tick();
      n++;
    end while (!acc && n < 500);
    if (!acc) check("push_timeout", 64'(0), 64'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((mq.size() > 0 || bq.size() > 0) && n < 3000) begin
      tick();
      n++;
    end
    if (mq.size() > 0 || bq.size() > 0) check("drain_timeout", 64'(0), 64'(1));
    wait_phase(0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit"}, 64'(ttc_bit_out), 64'(0));
    check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
    check({tag, "_level"}, 64'(fifo_level), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_bc"}, 64'(bc_strobe), 64'(0));
    check({tag, "_ovr"}, 64'(a_overrun), 64'(0));
`ifdef TTC_FRAME_CNT_EN
    check({tag, "_frames"}, 64'(frames_sent), 64'(0));
    check({tag, "_l1a"}, 64'(l1a_sent), 64'(0));
`endif
  endtask

  initial begin
    logic [7:0] idle_pat;
    int         a0;
    int         o0;
    checks    = 0;
    errors    = 0;
    b_hist    = '0;
    a_ones    = 0;
    ovr_seen  = 0;
    max_level = 0;
    idle_pat  = 8'b1101_0010;
    rst       = 1'b0;
    enable    = 1'b0;
    a_channel = 1'b0;
    cmd_long  = 1'b0;
    cmd_valid = 1'b0;
    cmd_frame = '0;
    reset_model();
    repeat (2) @(posedge clk160);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;

    // Idle pattern straight after reset release
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_pattern", 64'(ttc_bit_out), 64'(idle_pat[7-i]));
    end
    repeat (8) tick();

    // Single L1A request in a B cell
    wait_phase(2);
    a0 = a_ones;
    o0 = ovr_seen;
    a_channel = 1'b1;
    tick();
    a_channel = 1'b0;
    repeat (12) tick();
    check("single_a_count", 64'(a_ones - a0), 64'(1));
    check("single_a_ovr", 64'(ovr_seen - o0), 64'(0));

    // Two requests in one slot merge and flag overrun
    wait_phase(2);
    a0 = a_ones;
    o0 = ovr_seen;
    a_channel = 1'b1;
    repeat (2) tick();
    a_channel = 1'b0;
    repeat (12) tick();
    check("double_a_count", 64'(a_ones - a0), 64'(1));
    check("double_a_ovr", 64'(ovr_seen - o0), 64'(1));

    // Short frame
    enable = 1'b1;
    push_cmd(1'b0, 42'h1234);
    wait_drain();
    check("short_bits", 64'(b_hist[GAP+15:GAP]), 64'(16'h1234));
    check("short_gap", 64'(b_hist[0]), 64'(1));

    // Long frame followed immediately by a short one
    push_cmd(1'b1, 42'h0AB_CDEF_0123);
    push_cmd(1'b0, 42'h00F1);
    wait_drain();
    check("ls_short_bits", 64'(b_hist[GAP+15:GAP]), 64'(16'h00F1));
    check("ls_gap", 64'(b_hist[GAP+16]), 64'(1));
    check("ls_long_bits", 64'(b_hist[2*GAP+16+41:2*GAP+16]), 64'(42'h0AB_CDEF_0123));

    // Nine pushes into a depth-8 FIFO
    enable = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) push_cmd(1'(i % 2), 42'(64'h155_0000_0000 + 64'(i * 7919)));
    check("ready_full", 64'(cmd_ready), 64'(0));
    enable = 1'b1;
    push_cmd(1'b0, 42'h0BEEF);
    wait_drain();
    check("level_max", 64'(max_level), 64'(DEPTH));

    // enable dropped mid-frame: frame finishes, queue is retained
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 42'(16'hA5C0 + 16'(i)));
    repeat (20) tick();
    enable = 1'b0;
    repeat (120) tick();
    check("hold_level", 64'(fifo_level), 64'(2));
    check("hold_busy", 64'(busy), 64'(0));
    enable = 1'b1;
    wait_drain();

    // Randomised traffic
    for (int n = 0; n < 2500; n++) begin
      a_channel = ($urandom % 6) == 0;
      cmd_valid = ($urandom % 4) == 0;
      cmd_long  = 1'($urandom % 2);
      cmd_frame = {10'($urandom), 32'($urandom)};
      enable    = ($urandom % 8) != 0;
      tick();
    end
    a_channel = 1'b0;
    cmd_valid = 1'b0;
    enable    = 1'b1;
    wait_drain();

    // Reset in the middle of a long frame with three entries queued
    push_cmd(1'b1, 42'h3FF_0F0F_1234);
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 42'(16'h1111 * (i + 1)));
    repeat (40) tick();
    check("pre_rst_level", 64'(fifo_level), 64'(3));
    #2;
    rst       = 1'b0;
    enable    = 1'b0;
    a_channel = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk160);
    #1;
    rst    = 1'b1;
    reset_model();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_idle", 64'(ttc_bit_out), 64'(idle_pat[7-i]));
    end
    repeat (24) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttc_tdm_encoder.md
Name: ttc_tdm_encoder

Overview:
- Parametrised TTC line encoder running on the 160 MHz TTC clock.
- Time-multiplexes the A channel (L1A trigger bit) and the B channel (command frames) into one biphase-mark (BPM) serial stream for the optical TTC transmitter.
- Adds over the previous encoder: a command FIFO, both short-broadcast (16-bit) and long-addressed (42-bit) B frames, enforced inter-frame idle gap, A-channel request latching, and a bunch-crossing strobe.

Parameters:
- CMD_FIFO_DEPTH, 8, B-command FIFO depth in entries; power of 2, minimum 2.
- MIN_GAP, 1, minimum number of idle B bits ('1') between consecutive frames; range 0..15.

Ports:
- clk160  in  1  160 MHz TTC clock
- rst  in  1  asynchronous reset, active-low
- enable  in  1  1 = new B frames may start; 0 = in-progress frame completes, then B stays idle
- a_channel  in  1  L1A request pulse
- cmd_frame  in  42  B frame, MSB transmitted first; short frames occupy [15:0]
- cmd_long  in  1  1 = 42-bit frame, 0 = 16-bit frame
- cmd_valid  in  1  command push request
- cmd_ready  out  1  FIFO not full
- fifo_level  out  $clog2(CMD_FIFO_DEPTH)+1  current FIFO occupancy
- busy  out  1  B frame being transmitted, including trailing gap
- bc_strobe  out  1  high for the single cycle in which phase==0
- a_overrun  out  1  one-cycle pulse when an L1A request is merged
- ttc_bit_out  out  1  BPM serial output

Behaviour:
- Reset values: every output 0 except cmd_ready=1; phase=0; FIFO empty; a_pending=0; B shifter idle.
- Phase counter: 2-bit, increments every cycle, wraps 3→0. Phases 0–1 form the A cell; phases 2–3 form the B cell.
- BPM rule, evaluated at the clock edge using the current phase p:
  - p==0 or p==2: ttc_bit_out toggles.
  - p==1: ttc_bit_out ^= a_bit.
  - p==3: ttc_bit_out ^= b_bit.
- A channel:
  - Edge with p==0: a_bit <= a_pending | a_channel; a_pending <= 0.
  - Any other edge: a_pending <= a_pending | a_channel.
  - a_channel while a_pending==1 (p!=0): a_overrun pulses for one cycle and the requests merge into one L1A.
- B channel (all updates at edges with p==2):
  - Shifter loaded (bits_left>0, not in gap): b_bit <= next MSB; bits_left decrements. The last bit is followed by MIN_GAP idle bits.
  - Shifter idle, gap done, FIFO non-empty, enable=1: pop the FIFO head and load its frame (16 or 42 bits). b_bit <= first frame bit in this same edge.
  - Otherwise: b_bit <= 1 (idle).
  - No frame validation is performed. Hamming bits and start/stop bits are the caller's responsibility.
- busy: set at the load edge; cleared at the edge where the final gap bit is emitted.
- FIFO:
  - Push when cmd_valid & cmd_ready. Entries are {cmd_long, cmd_frame}.
  - Simultaneous push and pop is allowed; level is unchanged.
  - Push while full is not possible because cmd_ready=0. Pop while empty does not occur.
  - A push in the same cycle as a would-be pop is not visible until the next B cell.
  - Order is strictly FIFO.
- enable deasserted mid-frame: the current frame and its gap complete. No further pops occur; FIFO contents are retained.
- Reset asserted mid-operation: immediately returns every register to its reset value. The FIFO is flushed and any partial frame is abandoned.
- Latency: an A bit is transmitted in the A cell beginning at the next p==0 edge.

Optional Feature:
- Macro: TTC_FRAME_CNT_EN.
- Defined:
  - Adds outputs frames_sent[31:0] and l1a_sent[31:0].
  - frames_sent increments at each frame load edge; l1a_sent increments at each p==0 edge with a_bit set to 1.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Idle after reset release: ttc_bit_out sequence is 1,1,0,1,0,0,1,0, repeating with period 8; bc_strobe high every 4th cycle; B decodes as all 1s.
- Single a_channel pulse at a p==2 cycle: exactly one decoded A=1 in the next A cell, other A cells 0, a_overrun stays 0. Two pulses within one slot: one A=1 and a_overrun=1 for one cycle.
- Short frame cmd_frame=42'h1234, cmd_long=0: decoded B = 0001001000110100, then ≥MIN_GAP 1s. busy spans 16+MIN_GAP B cells; fifo_level returns to 0.
- Long frame cmd_frame=42'h0AB_CDEF_0123 with cmd_long=1, immediately followed by a short frame 42'h00F1: all 42 bits MSB-first, exactly MIN_GAP idle bits, then 0000000011110001.
- Push 9 frames back-to-back with depth 8: cmd_ready drops after the 8th push and the 9th is held until the first pop. All 9 frames are emitted in order; fifo_level never exceeds 8.
- Assert rst in the middle of a long frame with 3 entries queued: all outputs reach reset values immediately and fifo_level=0. After release, only the idle pattern is produced. With TTC_FRAME_CNT_EN defined, both counters read 0.
